// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencer: drives PC stall/shift/jump and pipeline flushes.
// Redirects that meet a busy instruction memory are held and replayed.
module fetch_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump_valid,
  input  logic [25:0]      jump_index,
  input  logic             load_use_hazard,
  input  logic             imem_ready,
  output logic             stall,
  output logic             shift_enable,
  output logic [31:0]      shift_inst_addr,
  output logic             jump_enable,
  output logic [25:0]      jump_inst_addr,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_nx;
  logic        pend_kind;
  logic [31:0] pend_addr;
  logic        cap;
  logic        cap_kind;
  logic [31:0] cap_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pend_kind <= 1'b0;
      pend_addr <= '0;
    end else begin
      state <= state_nx;
      if (cap) begin
        pend_kind <= cap_kind;
        pend_addr <= cap_addr;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    stall           = 1'b0;
    shift_enable    = 1'b0;
    shift_inst_addr = '0;
    jump_enable     = 1'b0;
    jump_inst_addr  = '0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    cap             = 1'b0;
    cap_kind        = 1'b0;
    cap_addr        = '0;
    if (rst) begin
      stall    = 1'b1;
      state_nx = RUN;
    end else if (state == RUN) begin
      unique case (1'b1)
        branch_taken: begin
          if (imem_ready) begin
            shift_enable    = 1'b1;
            shift_inst_addr = branch_target;
            flush_if_id     = 1'b1;
            flush_id_ex     = 1'b1;
          end else begin
            stall    = 1'b1;
            cap      = 1'b1;
            cap_addr = branch_target;
            state_nx = HOLD;
          end
        end
        (jump_valid && !load_use_hazard): begin
          if (imem_ready) begin
            jump_enable    = 1'b1;
            jump_inst_addr = jump_index;
            flush_if_id    = 1'b1;
          end else begin
            stall    = 1'b1;
            cap      = 1'b1;
            cap_kind = 1'b1;
            cap_addr = {6'b0, jump_index};
            state_nx = HOLD;
          end
        end
        default: begin
          stall       = load_use_hazard | ~imem_ready;
          flush_id_ex = load_use_hazard;
        end
      endcase
    end else begin
      // Frozen pipeline: only memory readiness matters here.
      if (imem_ready) begin
        flush_if_id = 1'b1;
        state_nx    = RUN;
        if (pend_kind) begin
          jump_enable    = 1'b1;
          jump_inst_addr = pend_addr[25:0];
        end else begin
          shift_enable    = 1'b1;
          shift_inst_addr = pend_addr;
          flush_id_ex     = 1'b1;
        end
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if ((shift_enable || jump_enable) && redirect_count != '1)
        redirect_count <= redirect_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl.
// A second instance with 4-bit counters covers saturation.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [25:0] jump_index;
  logic        load_use_hazard;
  logic        imem_ready;
  logic        stall, shift_enable, jump_enable;
  logic [31:0] shift_inst_addr;
  logic [25:0] jump_inst_addr;
  logic        flush_if_id, flush_id_ex;
  logic [15:0] stall_cycles, redirect_count;
  logic        s_stall, s_sh, s_jp, s_fi, s_fe;
  logic [31:0] s_sha;
  logic [25:0] s_jpa;
  logic [3:0]  s_sc, s_rc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_index(jump_index),
    .load_use_hazard(load_use_hazard), .imem_ready(imem_ready),
    .stall(stall), .shift_enable(shift_enable),
    .shift_inst_addr(shift_inst_addr), .jump_enable(jump_enable),
    .jump_inst_addr(jump_inst_addr), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .stall_cycles(stall_cycles),
    .redirect_count(redirect_count)
  );

  fetch_redirect_ctrl #(.CNT_W(4)) sat (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_index(jump_index),
    .load_use_hazard(load_use_hazard), .imem_ready(imem_ready),
    .stall(s_stall), .shift_enable(s_sh),
    .shift_inst_addr(s_sha), .jump_enable(s_jp),
    .jump_inst_addr(s_jpa), .flush_if_id(s_fi),
    .flush_id_ex(s_fe), .stall_cycles(s_sc),
    .redirect_count(s_rc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic bt, input logic [31:0] bta,
                       input logic jv, input logic [25:0] ji,
                       input logic hz, input logic rdy);
    branch_taken    = bt;
    branch_target   = bta;
    jump_valid      = jv;
    jump_index      = ji;
    load_use_hazard = hz;
    imem_ready      = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 32'h40, 1, 26'h10, 0, 1);
    tick();
    check("rst_stall", stall, 1);
    check("rst_shen", shift_enable, 0);
    check("rst_jpen", jump_enable, 0);
    check("rst_fl", {flush_if_id, flush_id_ex}, 0);
    check("rst_sha", shift_inst_addr, 0);
    check("rst_jpa", jump_inst_addr, 0);
    check("rst_cnt", {stall_cycles, redirect_count}, 0);
    rst = 1'b0;

    drive(1, 32'h40, 0, 0, 0, 1);
    check("br_shen", shift_enable, 1);
    check("br_sha", shift_inst_addr, 32'h40);
    check("br_fl", {flush_if_id, flush_id_ex}, 2'b11);
    check("br_stall", stall, 0);
    check("br_jpen", jump_enable, 0);
    tick();
    check("br_rc", redirect_count, 1);
    check("br_sc", stall_cycles, 0);

    drive(1, 32'h80, 1, 26'h10, 1, 1);
    check("all_shen", shift_enable, 1);
    check("all_jpen", jump_enable, 0);
    check("all_stall", stall, 0);
    check("all_sha", shift_inst_addr, 32'h80);
    tick();
    check("all_rc", redirect_count, 2);

    drive(0, 0, 1, 26'h22, 1, 1);
    check("hz_stall", stall, 1);
    check("hz_fe", flush_id_ex, 1);
    check("hz_fi", flush_if_id, 0);
    check("hz_jpen", jump_enable, 0);
    tick();
    check("hz_sc", stall_cycles, 1);
    drive(0, 0, 1, 26'h22, 0, 1);
    check("hz2_jpen", jump_enable, 1);
    check("hz2_jpa", jump_inst_addr, 26'h22);
    check("hz2_fl", {flush_if_id, flush_id_ex}, 2'b10);
    check("hz2_stall", stall, 0);
    tick();
    check("hz2_rc", redirect_count, 3);

    pulse_rst();
    drive(0, 0, 1, 26'h3FF0, 0, 0);
    check("hj_stall1", stall, 1);
    check("hj_en1", {shift_enable, jump_enable}, 0);
    check("hj_fl1", {flush_if_id, flush_id_ex}, 0);
    tick();
    drive(1, 32'h123, 0, 0, 1, 0);
    check("hj_stall2", stall, 1);
    check("hj_en2", {shift_enable, jump_enable}, 0);
    tick();
    drive(1, 32'h123, 1, 26'h7, 0, 0);
    check("hj_stall3", stall, 1);
    check("hj_en3", {shift_enable, jump_enable}, 0);
    tick();
    drive(1, 32'h200, 0, 0, 0, 1);
    check("hj_jpen", jump_enable, 1);
    check("hj_shen", shift_enable, 0);
    check("hj_jpa", jump_inst_addr, 26'h3FF0);
    check("hj_fl", {flush_if_id, flush_id_ex}, 2'b10);
    check("hj_stall", stall, 0);
    check("hj_sc", stall_cycles, 3);
    tick();
    check("hj_rc", redirect_count, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("hj_run", {stall, shift_enable, jump_enable}, 0);

    drive(1, 32'h44, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    check("hb_shen", shift_enable, 1);
    check("hb_sha", shift_inst_addr, 32'h44);
    check("hb_fl", {flush_if_id, flush_id_ex}, 2'b11);
    check("hb_jpen", jump_enable, 0);
    tick();
    check("hb_rc", redirect_count, 2);

    drive(0, 0, 1, 26'h5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("mr_stall", stall, 1);
    check("mr_cnt", {stall_cycles, redirect_count}, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    check("mr_en", {shift_enable, jump_enable}, 0);
    check("mr_stall2", stall, 0);
    tick();
    check("mr_cnt2", {stall_cycles, redirect_count}, 0);

    pulse_rst();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", s_sc, 4'hE);
    tick();
    check("sat_15", s_sc, 4'hF);
    for (int i = 0; i < 5; i++) tick();
    check("sat_20", s_sc, 4'hF);
    check("wide_20", stall_cycles, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequences the program counter register and the IF/ID and ID/EX pipeline registers. It takes redirect requests from EX (taken branch) and ID (jump), the load-use hazard from ID, and the instruction-memory ready signal. From these it drives the PC's `stall`, `shift_enable`/`shift_inst_addr` and `jump_enable`/`jump_inst_addr` inputs, plus the pipeline flush strobes. A redirect that arrives while instruction memory is busy is captured and replayed once memory is ready, so no redirect is ever lost.

## Interface
- `CNT_W`, 16, width of the saturating performance counters.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `branch_taken`  in  1  EX stage: taken branch this cycle.
- `branch_target`  in  32  EX stage: branch target byte address.
- `jump_valid`  in  1  ID stage: j/jal decoded this cycle.
- `jump_index`  in  26  ID stage: jump target field.
- `load_use_hazard`  in  1  ID stage: dependent instruction must wait one cycle.
- `imem_ready`  in  1  instruction memory can accept a fetch this cycle.
- `stall`  out  1  to PC: hold `inst_addr`.
- `shift_enable`  out  1  to PC: load `shift_inst_addr`.
- `shift_inst_addr`  out  32  to PC: branch target.
- `jump_enable`  out  1  to PC: load `jump_inst_addr`.
- `jump_inst_addr`  out  26  to PC: jump target field.
- `flush_if_id`  out  1  clear the IF/ID register at the next edge.
- `flush_id_ex`  out  1  insert a bubble into ID/EX at the next edge.
- `stall_cycles`  out  CNT_W  count of cycles with `stall`=1, saturating.
- `redirect_count`  out  CNT_W  count of redirects delivered to the PC, saturating.

## Operation
- Registered state: `state` ∈ {RUN, HOLD}, `pend_kind` (0 = branch, 1 = jump), `pend_addr[31:0]` (holds a jump as {6'b0, index}), and two counters.
- Request priority in RUN: `branch_taken` > `jump_valid` > `load_use_hazard`.
  - A branch discards a simultaneous jump and hazard, because both are wrong-path.
  - `jump_valid` is ignored while `load_use_hazard`=1; ID re-presents it next cycle.
- **RUN, branch, `imem_ready`=1:** `shift_enable`=1, `shift_inst_addr`=`branch_target`, `stall`=0, `flush_if_id`=1, `flush_id_ex`=1. Stay in RUN.
- **RUN, jump (no branch, no hazard), `imem_ready`=1:** `jump_enable`=1, `jump_inst_addr`=`jump_index`, `stall`=0, `flush_if_id`=1, `flush_id_ex`=0.
- **RUN, redirect, `imem_ready`=0:**
  - No enables are driven; `stall`=1 and the flush outputs are 0.
  - Capture kind and target into `pend_*`, then go to HOLD.
- **RUN, no redirect:** `stall` = `load_use_hazard` | ~`imem_ready`.
  - `flush_id_ex` = `load_use_hazard` (bubble).
  - `flush_if_id`=0.
- **HOLD:**
  - Inputs `branch_taken`, `jump_valid` and `load_use_hazard` are ignored, because the pipeline is frozen.
  - While `imem_ready`=0: `stall`=1, no enables, no flushes.
  - On the first cycle with `imem_ready`=1: present the pending redirect exactly as RUN would (same enable, address and flush pattern, taken from `pend_*`), with `stall`=0. Then return to RUN.
- The two enables are never asserted together, and an enable is never asserted while `stall`=1.
- Counters:
  - `stall_cycles` increments on each cycle with `stall`=1.
  - `redirect_count` increments on each cycle with `shift_enable` | `jump_enable`.
  - Both saturate at all-ones and never wrap.

## Timing
- Output logic is combinational from the inputs and registered state. Redirect latency in RUN with memory ready is 0 cycles: the PC loads the target at the same edge.
- The HOLD replay is issued in the same cycle that `imem_ready` rises.
- Reset (asynchronous, any time, including while in HOLD) forces the following; outputs hold these values while `rst`=1:
  - `state`=RUN; `pend_*` cleared; both counters 0.
  - `stall`=1; `shift_enable`=0; `jump_enable`=0; both flush outputs 0.
  - `shift_inst_addr`=0; `jump_inst_addr`=0.
- A pending redirect is discarded by reset and is not replayed.

## Test plan
- Branch in RUN: `branch_taken`=1, `branch_target`=0x00000040, `imem_ready`=1 → same cycle `shift_enable`=1, `shift_inst_addr`=0x40, both flushes=1, `stall`=0; `redirect_count`=1.
- Simultaneous branch, jump and hazard: `branch_taken`=1 (target 0x80), `jump_valid`=1 (index 0x10), `load_use_hazard`=1 → only `shift_enable`=1, `jump_enable`=0, `stall`=0.
- Load-use hazard: `load_use_hazard`=1 for 1 cycle, `jump_valid`=1 in the same cycle → `stall`=1, `flush_id_ex`=1, `jump_enable`=0; next cycle with the hazard cleared, `jump_enable`=1.
- Held redirect: jump index 0x3FF0 with `imem_ready`=0 for 3 cycles → `stall`=1 for 3 cycles, and branch pulses during HOLD are ignored. On the cycle `imem_ready`=1: `jump_enable`=1, `jump_inst_addr`=0x3FF0, `flush_if_id`=1. `stall_cycles`=3.
- Reset mid-HOLD: assert `rst` while in HOLD, release, then `imem_ready`=1 → no enable asserted; counters 0.
- Saturation: with `CNT_W`=4, hold `imem_ready`=0 for 20 cycles → `stall_cycles`=0xF and it stays there.
